vga_sync: RTL and testbench

Timing generator for the 640x480 @ 60 Hz VGA controller. Divides the 100 MHz system clock into a 25 MHz pixel enable, runs horizontal/vertical counters and produces registered hsync/vsync plus `video_on`, `pixel_x` and `pixel_y`. It sits directly upstream of the text/data generator, which turns the pixel coordinates into `rgb_text`, and drives the board sync pins.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_tick_gen.sv | 27 ++
 rtl/vga_sync.sv | 112 +++++++++++
 tb/tb_vga_sync.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and coordinate type for vga_sync
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV   = 4;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Inclusive sync windows, expressed on the count value.
    localparam int DEF_H_SYNC_LO = DEF_H_DISPLAY + DEF_H_FP;
    localparam int DEF_H_SYNC_HI = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_LO = DEF_V_DISPLAY + DEF_V_FP;
    localparam int DEF_V_SYNC_HI = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_tick_gen.sv
// rtl/vga_tick_gen.sv - system-clock divider producing the one-clk pixel enable
module vga_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign p_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA h/v counters, registered syncs, video_on and frame pulse
// Optional frame_cnt output enabled by VGA_SYNC_FRAME_CNT_EN.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               p_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic [7:0]         frame_cnt,
`endif
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    // All sums stay below 1024, so these casts never drop bits.
    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS     = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS     = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_LO = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_LO = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   w_p_tick;
    coord_t r_h_cnt, r_v_cnt;
    coord_t w_h_next, w_v_next;
    logic   r_hsync, r_vsync;

    vga_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .p_tick(w_p_tick)
    );

    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_p_tick) begin
            if (r_h_cnt == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                w_h_next = r_h_cnt + 1'b1;
            end
        end
    end

    // Syncs decode the next counts so they switch on the same edge as the coordinates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_hsync <= !((w_h_next >= H_SYNC_LO) && (w_h_next <= H_SYNC_HI));
            r_vsync <= !((w_v_next >= V_SYNC_LO) && (w_v_next <= V_SYNC_HI));
        end
    end

    assign p_tick      = w_p_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign video_on    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign frame_start = w_p_tick && (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    logic       r_first_seen;

    // The pulse right after reset marks frame 0, so it is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_first_seen <= 1'b0;
        end else if (frame_start) begin
            if (r_first_seen) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            r_first_seen <= 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - scoreboard bench for vga_sync (default and reduced timing; VGA_SYNC_FRAME_CNT_EN optional)
module tb_vga_sync;

    localparam int S_CD = 2, S_HD = 8, S_HFP = 1, S_HS = 2, S_HBP = 1;
    localparam int S_VD = 4, S_VFP = 1, S_VS = 2, S_VBP = 1;
`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam int OW = 33;
`else
    localparam int OW = 25;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       d_p_tick, d_hsync, d_vsync, d_video_on, d_frame_start;
    logic [9:0] d_x, d_y;
    logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_start;
    logic [9:0] s_x, s_y;
    logic [OW-1:0] obs_d, obs_s;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc;
    assign obs_d = {d_fc, d_p_tick, d_frame_start, d_hsync, d_vsync, d_video_on, d_x, d_y};
    assign obs_s = {s_fc, s_p_tick, s_frame_start, s_hsync, s_vsync, s_video_on, s_x, s_y};
`else
    assign obs_d = {d_p_tick, d_frame_start, d_hsync, d_vsync, d_video_on, d_x, d_y};
    assign obs_s = {s_p_tick, s_frame_start, s_hsync, s_vsync, s_video_on, s_x, s_y};
`endif

    vga_sync dut_d (
        .clk(clk), .rst_n(rst_n), .p_tick(d_p_tick), .hsync(d_hsync), .vsync(d_vsync),
        .video_on(d_video_on), .pixel_x(d_x), .pixel_y(d_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .frame_start(d_frame_start)
    );

    vga_sync #(
        .CLK_DIV(S_CD), .H_DISPLAY(S_HD), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_DISPLAY(S_VD), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .p_tick(s_p_tick), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_video_on), .pixel_x(s_x), .pixel_y(s_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .frame_start(s_frame_start)
    );

    int checks = 0;
    int failures = 0;
    int t_m = 0;
    int fc_d = 0, fc_s = 0;
    bit seen_d = 0, seen_s = 0;
    logic [OW-1:0] q_d[$];
    logic [OW-1:0] q_s[$];
    logic [OW-1:0] ed, es;

    // Expected outputs as a function of clocks elapsed since the reset cycle.
    function automatic logic [24:0] exp_out(input int t, input int cd, input int hd, input int hfp,
                                            input int hs, input int hbp, input int vd, input int vfp,
                                            input int vs, input int vbp);
        int pix, ht, vt, x, y;
        logic pt, fs, hsy, vsy, von;
        pix = t / cd;
        ht  = hd + hfp + hs + hbp;
        vt  = vd + vfp + vs + vbp;
        x   = pix % ht;
        y   = (pix / ht) % vt;
        pt  = (t % cd) == cd - 1;
        fs  = pt && (x == 0) && (y == 0);
        hsy = !((x >= hd + hfp) && (x < hd + hfp + hs));
        vsy = !((y >= vd + vfp) && (y < vd + vfp + vs));
        von = (x < hd) && (y < vd);
        return {pt, fs, hsy, vsy, von, x[9:0], y[9:0]};
    endfunction

    // Predicts the state after the coming edge, queues it, then waits to the sample point.
    task automatic cyc();
        int tn;
        logic [24:0] now_d, now_s;
        now_d = exp_out(t_m, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        now_s = exp_out(t_m, S_CD, S_HD, S_HFP, S_HS, S_HBP, S_VD, S_VFP, S_VS, S_VBP);
        if (!rst_n) begin
            tn = 0; fc_d = 0; fc_s = 0; seen_d = 0; seen_s = 0;
        end else begin
            tn = t_m + 1;
            if (now_d[23]) begin if (seen_d) fc_d = (fc_d + 1) % 256; seen_d = 1; end
            if (now_s[23]) begin if (seen_s) fc_s = (fc_s + 1) % 256; seen_s = 1; end
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        q_d.push_back({8'(fc_d), exp_out(tn, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
        q_s.push_back({8'(fc_s), exp_out(tn, S_CD, S_HD, S_HFP, S_HS, S_HBP, S_VD, S_VFP, S_VS, S_VBP)});
`else
        q_d.push_back(exp_out(tn, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q_s.push_back(exp_out(tn, S_CD, S_HD, S_HFP, S_HS, S_HBP, S_VD, S_VFP, S_VS, S_VBP));
`endif
        t_m = tn;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL reset_d got=%h exp=%h", obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL reset_s got=%h exp=%h", obs_s, es); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 3;
            if (obs_d !== ed) begin failures++; $display("FAIL release_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL release_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (d_p_tick !== (t_m % 4 == 3)) begin
                failures++; $display("FAIL first_ticks t=%0d got=%b exp=%b", t_m, d_p_tick, t_m % 4 == 3);
            end
        end
    endtask

    task automatic test_line();
        int hl = 0;
        int first_x = -1;
        for (int i = 0; i < 3200; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL line_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL line_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (d_hsync === 1'b0) begin
                if (first_x < 0) first_x = int'(d_x);
                hl++;
            end
        end
        checks += 2;
        if (hl !== 384) begin failures++; $display("FAIL hsync_width got=%0d exp=384", hl); end
        if (first_x !== 656) begin failures++; $display("FAIL hsync_start_x got=%0d exp=656", first_x); end
    endtask

    task automatic test_frame();
        int start = -1, stop = -1, vlow = 0;
        for (int i = 0; i < 1000 && stop < 0; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL frame_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL frame_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (s_frame_start === 1'b1) begin
                if (start < 0) start = i; else stop = i;
            end
            if (start >= 0 && stop < 0 && s_vsync === 1'b0) vlow++;
        end
        checks += 2;
        if (stop < 0) begin
            failures++; $display("FAIL frame_timeout got=%0d exp=2 frame_start pulses", start < 0 ? 0 : 1);
        end else begin
            if (stop - start !== 192) begin failures++; $display("FAIL frame_period got=%0d exp=192", stop - start); end
            if (vlow !== 48) begin failures++; $display("FAIL vsync_width got=%0d exp=48", vlow); end
        end
    endtask

    task automatic test_visible();
        bit a = 0, b = 0, c = 0;
        for (int i = 0; i < 400 && !(a && b && c); i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL vis_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL vis_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (s_x == 10'd7 && s_y == 10'd3 && !a) begin
                a = 1; checks++;
                if (s_video_on !== 1'b1) begin failures++; $display("FAIL vis_last_pixel got=%b exp=1", s_video_on); end
            end
            if (s_x == 10'd8 && s_y == 10'd3 && !b) begin
                b = 1; checks++;
                if (s_video_on !== 1'b0) begin failures++; $display("FAIL vis_right_edge got=%b exp=0", s_video_on); end
            end
            if (s_x == 10'd0 && s_y == 10'd4 && !c) begin
                c = 1; checks++;
                if (s_video_on !== 1'b0) begin failures++; $display("FAIL vis_bottom_edge got=%b exp=0", s_video_on); end
            end
        end
        checks++;
        if (!(a && b && c)) begin failures++; $display("FAIL vis_timeout got=%0b%0b%0b exp=111", a, b, c); end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        for (int i = 0; i < 3400 && !hit; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL pre_rst_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL pre_rst_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (d_x == 10'd700) hit = 1;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL mid_rst_timeout got=%0d exp=700", d_x); end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        ed = q_d.pop_front(); es = q_s.pop_front();
        checks += 3;
        if (obs_d !== ed) begin failures++; $display("FAIL mid_rst_d got=%h exp=%h", obs_d, ed); end
        if (obs_s !== es) begin failures++; $display("FAIL mid_rst_s got=%h exp=%h", obs_s, es); end
        if ({d_x, d_y, d_hsync, d_vsync, d_p_tick} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mid_rst_state got=(%0d,%0d,%b,%b,%b) exp=(0,0,1,1,0)", d_x, d_y, d_hsync, d_vsync, d_p_tick);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 3;
            if (obs_d !== ed) begin failures++; $display("FAIL post_rst_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL post_rst_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (d_p_tick !== (i == 2)) begin failures++; $display("FAIL post_rst_tick i=%0d got=%b exp=%b", i, d_p_tick, i == 2); end
        end
    endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int n = 0;
        bit chk4 = 0, chk257 = 0, done = 0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        void'(q_d.pop_front()); void'(q_s.pop_front());
        for (int i = 0; i < 257 * 192 + 400 && !done; i++) begin
            cyc();
            ed = q_d.pop_front(); es = q_s.pop_front();
            checks += 2;
            if (obs_d !== ed) begin failures++; $display("FAIL fc_d t=%0d got=%h exp=%h", t_m, obs_d, ed); end
            if (obs_s !== es) begin failures++; $display("FAIL fc_s t=%0d got=%h exp=%h", t_m, obs_s, es); end
            if (chk4) begin
                chk4 = 0; checks++;
                if (s_fc !== 8'd3) begin failures++; $display("FAIL frame_cnt_4th got=%0d exp=3", s_fc); end
            end
            if (chk257) begin
                done = 1; checks++;
                if (s_fc !== 8'd0) begin failures++; $display("FAIL frame_cnt_wrap got=%0d exp=0", s_fc); end
            end
            if (s_frame_start === 1'b1) begin
                n++;
                if (n == 4) chk4 = 1;
                if (n == 257) chk257 = 1;
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL frame_cnt_timeout got=%0d exp=257 pulses", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_visible();
        test_mid_reset();
`ifdef VGA_SYNC_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
